// File: rtl/axi_int_block.sv
// rtl/axi_int_block.sv - AXI4-Lite test peripheral raising a level interrupt a fixed delay after a DATA write
`timescale 1ns/1ps
module axi_int_block #(
    parameter int DELAY_MAX               = 100_000_000,
    parameter int C_S00_AXI_DATA_WIDTH    = 32,
    parameter int C_S00_AXI_ADDR_WIDTH    = 4,
    parameter int C_S_AXI_INTR_DATA_WIDTH = 32,
    parameter int C_S_AXI_INTR_ADDR_WIDTH = 5
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    input  logic [C_S_AXI_INTR_ADDR_WIDTH-1:0]     s_axi_intr_awaddr,
    input  logic [2:0]                             s_axi_intr_awprot,
    input  logic                                   s_axi_intr_awvalid,
    output logic                                   s_axi_intr_awready,
    input  logic [C_S_AXI_INTR_DATA_WIDTH-1:0]     s_axi_intr_wdata,
    input  logic [C_S_AXI_INTR_DATA_WIDTH/8-1:0]   s_axi_intr_wstrb,
    input  logic                                   s_axi_intr_wvalid,
    output logic                                   s_axi_intr_wready,
    output logic [1:0]                             s_axi_intr_bresp,
    output logic                                   s_axi_intr_bvalid,
    input  logic                                   s_axi_intr_bready,
    input  logic [C_S_AXI_INTR_ADDR_WIDTH-1:0]     s_axi_intr_araddr,
    input  logic [2:0]                             s_axi_intr_arprot,
    input  logic                                   s_axi_intr_arvalid,
    output logic                                   s_axi_intr_arready,
    output logic [C_S_AXI_INTR_DATA_WIDTH-1:0]     s_axi_intr_rdata,
    output logic [1:0]                             s_axi_intr_rresp,
    output logic                                   s_axi_intr_rvalid,
    input  logic                                   s_axi_intr_rready,
    output logic                                   irq
);
    localparam int CW = $clog2(DELAY_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(DELAY_MAX - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, WAITING = 2'b01, INTERRUPT = 2'b10, DONE = 2'b11} state_t;

    state_t                            state, state_next;
    logic [CW-1:0]                     counter;
    logic                              pending;
    logic [C_S00_AXI_DATA_WIDTH-1:0]   data_reg;
    logic                              int_en;
    logic                              gie;
    logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_rmux;
    logic [C_S_AXI_INTR_DATA_WIDTH-1:0] intr_rmux;

    // Ready is combinational so a handshake completes in the cycle valid is first seen
    logic s00_wr, s00_rd, intr_wr, intr_rd;
    assign s00_wr  = s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_areset;
    assign s00_rd  = s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_areset;
    assign intr_wr = s_axi_intr_awvalid & s_axi_intr_wvalid & ~s_axi_intr_bvalid & ~s00_axi_areset;
    assign intr_rd = s_axi_intr_arvalid & ~s_axi_intr_rvalid & ~s00_axi_areset;

    assign s00_axi_awready    = s00_wr;
    assign s00_axi_wready     = s00_wr;
    assign s00_axi_arready    = s00_rd;
    assign s_axi_intr_awready = intr_wr;
    assign s_axi_intr_wready  = intr_wr;
    assign s_axi_intr_arready = intr_rd;
    assign s00_axi_bresp      = 2'b00;
    assign s00_axi_rresp      = 2'b00;
    assign s_axi_intr_bresp   = 2'b00;
    assign s_axi_intr_rresp   = 2'b00;

    logic data_wr, ctrl_wr;
    assign data_wr = s00_wr && (s00_axi_awaddr[3:2] == 2'd0);
    assign ctrl_wr = s00_wr && (s00_axi_awaddr[3:2] == 2'd1);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state   <= IDLE;
            counter <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= (state_next == INTERRUPT);
            if (state == WAITING && state_next == WAITING)
                counter <= counter + 1'b1;
            else
                counter <= '0;
        end
    end

    // CTRL bit1 (back to IDLE) takes priority over everything, including bit0 in the same write
    always_comb begin
        state_next = state;
        if (ctrl_wr && s00_axi_wdata[1]) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (data_wr) state_next = WAITING;
                WAITING:   if (counter == LAST) state_next = INTERRUPT;
                INTERRUPT: if (ctrl_wr && s00_axi_wdata[0]) state_next = DONE;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        irq = pending & int_en & gie;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            data_reg          <= '0;
            int_en            <= 1'b0;
            gie               <= 1'b0;
            s00_axi_bvalid    <= 1'b0;
            s00_axi_rvalid    <= 1'b0;
            s00_axi_rdata     <= '0;
            s_axi_intr_bvalid <= 1'b0;
            s_axi_intr_rvalid <= 1'b0;
            s_axi_intr_rdata  <= '0;
        end else begin
            if (data_wr) begin
                for (int b = 0; b < C_S00_AXI_DATA_WIDTH / 8; b++)
                    if (s00_axi_wstrb[b]) data_reg[b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
            end
            if (s00_wr && s00_axi_awaddr[3:2] == 2'd3 && s00_axi_wstrb[0])
                int_en <= s00_axi_wdata[0];
            if (intr_wr && s_axi_intr_awaddr[4:2] == 3'd0 && s_axi_intr_wstrb[0])
                gie <= s_axi_intr_wdata[0];

            if (s00_wr)              s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
            if (s00_rd) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= s00_rmux;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end

            if (intr_wr)                s_axi_intr_bvalid <= 1'b1;
            else if (s_axi_intr_bready) s_axi_intr_bvalid <= 1'b0;
            if (intr_rd) begin
                s_axi_intr_rvalid <= 1'b1;
                s_axi_intr_rdata  <= intr_rmux;
            end else if (s_axi_intr_rready) begin
                s_axi_intr_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        s00_rmux = '0;
        case (s00_axi_araddr[3:2])
            2'd0:    s00_rmux = data_reg;
            2'd2:    s00_rmux[2:0] = {state, pending};
            2'd3:    s00_rmux[0] = int_en;
            default: s00_rmux = '0;
        endcase
    end

    always_comb begin
        intr_rmux = '0;
        case (s_axi_intr_araddr[4:2])
            3'd0:    intr_rmux[0] = gie;
            3'd1:    intr_rmux[0] = pending;
            default: intr_rmux = '0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s_axi_intr_awprot, s_axi_intr_arprot, s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0],
                         s_axi_intr_wdata[C_S_AXI_INTR_DATA_WIDTH-1:1],
                         s_axi_intr_wstrb[C_S_AXI_INTR_DATA_WIDTH/8-1:1]};
endmodule

// File: tb/tb_axi_int_block.sv
// tb/tb_axi_int_block.sv - randomized self-checking bench for axi_int_block against a timeline reference model
`timescale 1ns/1ps
module tb_axi_int_block;
    localparam int DELAY = 100;
    localparam int P     = 10;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  s_awaddr, s_araddr;
    logic [4:0]  i_awaddr, i_araddr;
    logic [2:0]  s_awprot, s_arprot, i_awprot, i_arprot;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic [31:0] s_wdata, i_wdata, s_rdata, i_rdata;
    logic [3:0]  s_wstrb, i_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic        i_awready, i_wready, i_bvalid, i_arready, i_rvalid;
    logic [1:0]  s_bresp, s_rresp, i_bresp, i_rresp;
    logic        irq;

    always #5 clk = ~clk;

    axi_int_block #(.DELAY_MAX(DELAY)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(s_awaddr), .s00_axi_awprot(s_awprot), .s00_axi_awvalid(s_awvalid), .s00_axi_awready(s_awready),
        .s00_axi_wdata(s_wdata), .s00_axi_wstrb(s_wstrb), .s00_axi_wvalid(s_wvalid), .s00_axi_wready(s_wready),
        .s00_axi_bresp(s_bresp), .s00_axi_bvalid(s_bvalid), .s00_axi_bready(s_bready),
        .s00_axi_araddr(s_araddr), .s00_axi_arprot(s_arprot), .s00_axi_arvalid(s_arvalid), .s00_axi_arready(s_arready),
        .s00_axi_rdata(s_rdata), .s00_axi_rresp(s_rresp), .s00_axi_rvalid(s_rvalid), .s00_axi_rready(s_rready),
        .s_axi_intr_awaddr(i_awaddr), .s_axi_intr_awprot(i_awprot), .s_axi_intr_awvalid(i_awvalid), .s_axi_intr_awready(i_awready),
        .s_axi_intr_wdata(i_wdata), .s_axi_intr_wstrb(i_wstrb), .s_axi_intr_wvalid(i_wvalid), .s_axi_intr_wready(i_wready),
        .s_axi_intr_bresp(i_bresp), .s_axi_intr_bvalid(i_bvalid), .s_axi_intr_bready(i_bready),
        .s_axi_intr_araddr(i_araddr), .s_axi_intr_arprot(i_arprot), .s_axi_intr_arvalid(i_arvalid), .s_axi_intr_arready(i_arready),
        .s_axi_intr_rdata(i_rdata), .s_axi_intr_rresp(i_rresp), .s_axi_intr_rvalid(i_rvalid), .s_axi_intr_rready(i_rready),
        .irq(irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: architectural phase (00 idle, 01 waiting, 10 interrupt, 11 done) plus the time waiting began
    logic [31:0] m_data = '0;
    logic        m_en = 1'b0, m_gie = 1'b0;
    int          m_phase = 0;
    time         m_start = 0;

    // State seen at time t: waiting has expired once more than DELAY clock periods have passed since entry
    task automatic model_sync(input time t);
        if (m_phase == 1 && (t - m_start) > DELAY * P) m_phase = 2;
    endtask

    task automatic model_write(input bit p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input time t);
        model_sync(t);
        if (!p) begin
            case (a[3:2])
                2'd0: begin
                    for (int b = 0; b < 4; b++) if (s[b]) m_data[b*8 +: 8] = d[b*8 +: 8];
                    if (m_phase == 0) begin m_phase = 1; m_start = t; end
                end
                2'd1: if (d[1]) m_phase = 0; else if (d[0] && m_phase == 2) m_phase = 3;
                2'd3: if (s[0]) m_en = d[0];
                default: ;
            endcase
        end else if (a[4:2] == 3'd0 && s[0]) begin
            m_gie = d[0];
        end
    endtask

    function automatic logic [31:0] model_read(input bit p, input logic [4:0] a);
        logic [1:0] ph = 2'(m_phase);
        if (!p) begin
            case (a[3:2])
                2'd0:    return m_data;
                2'd2:    return {29'd0, ph, m_phase == 2};
                2'd3:    return {31'd0, m_en};
                default: return 32'd0;
            endcase
        end
        if (a[4:2] == 3'd0) return {31'd0, m_gie};
        if (a[4:2] == 3'd1) return {31'd0, m_phase == 2};
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_irq();
        return {31'd0, (m_phase == 2) && m_en && m_gie};
    endfunction

    logic irq_after;

    task automatic axi_write(input bit p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        int n;
        @(negedge clk);
        if (!p) begin s_awaddr = a[3:0]; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1; end
        else    begin i_awaddr = a;      i_wdata = d; i_wstrb = s; i_awvalid = 1; i_wvalid = 1; end
        #1;
        n = 0;
        while (!(p ? (i_awready & i_wready) : (s_awready & s_wready)) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) check("aw_timeout", 32'd0, 32'd1);
        @(posedge clk);
        model_write(p, a, d, s, $time);
        #1;
        if (hold == 0) begin s_awvalid = 0; s_wvalid = 0; i_awvalid = 0; i_wvalid = 0; end
        #3;
        irq_after = irq;
        n = 0;
        while (!(p ? i_bvalid : s_bvalid) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("bvalid_timeout", 32'd0, 32'd1);
        check("bresp", {30'd0, p ? i_bresp : s_bresp}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("b_hold_valid", {31'd0, p ? i_bvalid : s_bvalid}, 32'd1);
            check("b_hold_awready", {31'd0, p ? i_awready : s_awready}, 32'd0);
        end
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; i_awvalid = 0; i_wvalid = 0;
        if (p) i_bready = 1; else s_bready = 1;
        @(posedge clk);
        #1;
        s_bready = 0; i_bready = 0;
    endtask

    task automatic axi_read(input bit p, input logic [4:0] a, input int hold, output logic [31:0] d);
        int n;
        @(negedge clk);
        if (!p) begin s_araddr = a[3:0]; s_arvalid = 1; end
        else    begin i_araddr = a;      i_arvalid = 1; end
        #1;
        n = 0;
        while (!(p ? i_arready : s_arready) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) check("ar_timeout", 32'd0, 32'd1);
        @(posedge clk);
        model_sync($time);
        #1;
        if (hold == 0) begin s_arvalid = 0; i_arvalid = 0; end
        @(negedge clk);
        n = 0;
        while (!(p ? i_rvalid : s_rvalid) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("rvalid_timeout", 32'd0, 32'd1);
        d = p ? i_rdata : s_rdata;
        check("rresp", {30'd0, p ? i_rresp : s_rresp}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("r_hold_valid", {31'd0, p ? i_rvalid : s_rvalid}, 32'd1);
            check("r_hold_data", p ? i_rdata : s_rdata, d);
            check("r_hold_arready", {31'd0, p ? i_arready : s_arready}, 32'd0);
        end
        s_arvalid = 0; i_arvalid = 0;
        if (p) i_rready = 1; else s_rready = 1;
        @(posedge clk);
        #1;
        s_rready = 0; i_rready = 0;
    endtask

    task automatic read_check(input string tag, input bit p, input logic [4:0] a);
        logic [31:0] d;
        axi_read(p, a, 0, d);
        check(tag, d, model_read(p, a));
    endtask

    task automatic poll_irq(input int cycles, input bit check_rise);
        time first = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            model_sync($time);
            check("irq_poll", {31'd0, irq}, model_irq());
            if (irq && first == 0) first = $time;
        end
        if (check_rise) check("irq_rise_clks", 32'((first - m_start) / P), DELAY);
    endtask

    logic [31:0] rd, rv;
    logic [3:0]  rs;
    bit          re, rg;

    initial begin
        areset = 1;
        s_awaddr = 0; s_araddr = 0; i_awaddr = 0; i_araddr = 0;
        s_awprot = 0; s_arprot = 0; i_awprot = 0; i_arprot = 0;
        s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF; i_wdata = 0; i_wstrb = 0;
        s_awvalid = 1; s_wvalid = 1; s_bready = 0; s_arvalid = 1; s_rready = 0;
        i_awvalid = 0; i_wvalid = 0; i_bready = 0; i_arvalid = 0; i_rready = 0;
        // A transaction offered during reset must be dropped
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, s_awready}, 32'd0);
        check("rst_arready", {31'd0, s_arready}, 32'd0);
        check("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        areset = 0;
        @(negedge clk);
        check("post_rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        read_check("rst_data", 0, 5'h00);
        read_check("rst_status", 0, 5'h08);

        axi_write(0, 5'h0C, 32'h1, 4'hF, 0);
        axi_write(1, 5'h00, 32'h1, 4'hF, 0);
        axi_read(0, 5'h0C, 0, rd); check("int_en_rd", rd, 32'h1);
        axi_read(1, 5'h00, 0, rd); check("gie_rd", rd, 32'h1);
        read_check("ctrl_rd0", 0, 5'h04);

        axi_write(0, 5'h00, 32'hA5A5_A5A5, 4'hF, 0);
        axi_read(0, 5'h00, 0, rd); check("data_rd", rd, 32'hA5A5_A5A5);
        axi_read(0, 5'h08, 0, rd); check("status_wait", rd, 32'h2);
        check("irq_wait", {31'd0, irq}, 32'd0);
        poll_irq(DELAY + 5, 1'b1);
        axi_read(0, 5'h08, 0, rd); check("status_int", rd, 32'h5);
        read_check("intr_pending", 1, 5'h04);

        axi_write(1, 5'h00, 32'h0, 4'hF, 0);
        check("gie_mask_irq", {31'd0, irq_after}, 32'd0);
        axi_read(0, 5'h08, 0, rd); check("gie_mask_status", rd, 32'h5);
        axi_write(1, 5'h00, 32'h1, 4'hF, 0);
        check("gie_unmask_irq", {31'd0, irq_after}, 32'd1);

        axi_write(0, 5'h04, 32'h1, 4'hF, 0);
        check("ack_irq_next", {31'd0, irq_after}, 32'd0);
        axi_read(0, 5'h08, 0, rd); check("status_done", rd, 32'h6);
        axi_write(0, 5'h04, 32'h2, 4'hF, 0);
        axi_read(0, 5'h08, 0, rd); check("status_idle", rd, 32'h0);

        axi_write(0, 5'h04, 32'h1, 4'hF, 0);
        read_check("ack_in_idle", 0, 5'h08);
        axi_write(0, 5'h00, 32'h1234_5678, 4'hF, 0);
        poll_irq(DELAY + 3, 1'b1);
        axi_write(0, 5'h04, 32'h3, 4'hF, 0);
        axi_read(0, 5'h08, 0, rd); check("ctrl3_idle", rd, 32'h0);
        read_check("ctrl3_pending", 1, 5'h04);

        axi_write(0, 5'h00, 32'h0BAD_F00D, 4'hF, 0);
        poll_irq(50, 1'b0);
        axi_write(0, 5'h00, 32'hFEED_BEEF, 4'h5, 0);
        poll_irq(DELAY, 1'b1);
        read_check("data_merge", 0, 5'h00);
        axi_write(0, 5'h04, 32'h2, 4'hF, 0);

        axi_write(1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 5);
        read_check("intr_unmapped", 1, 5'h1C);
        read_check("gie_kept", 1, 5'h00);
        axi_read(0, 5'h00, 5, rd); check("hold_rdata", rd, model_read(0, 5'h00));

        for (int r = 0; r < 4; r++) begin
            re = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            axi_write(0, 5'h0C, {31'($urandom), re}, 4'hF, 0);
            axi_write(1, 5'h00, {31'($urandom), rg}, 4'hF, 0);
            rv = $urandom;
            rs = 4'($urandom_range(1, 15));
            axi_write(0, 5'h00, rv, rs, 0);
            read_check("rnd_data", 0, 5'h00);
            read_check("rnd_status_wait", 0, 5'h08);
            if ($urandom_range(0, 1) == 1) axi_write(0, 5'h00, $urandom, 4'hF, 0);
            poll_irq(DELAY + 10, re & rg);
            read_check("rnd_status_int", 0, 5'h08);
            read_check("rnd_pending", 1, 5'h04);
            read_check("rnd_int_en", 0, 5'h0C);
            case ($urandom_range(0, 2))
                0: begin
                    axi_write(0, 5'h04, 32'h1, 4'hF, 0);
                    check("rnd_ack_irq", {31'd0, irq_after}, 32'd0);
                    read_check("rnd_status_done", 0, 5'h08);
                    axi_write(0, 5'h04, 32'h2, 4'hF, 0);
                end
                1: axi_write(0, 5'h04, 32'h3, 4'hF, 0);
                default: axi_write(0, 5'h04, 32'h2, 4'hF, 0);
            endcase
            read_check("rnd_status_idle", 0, 5'h08);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
